// File: rtl/avaliador_ritmo.sv
// avaliador_ritmo: step-by-step note and rhythm evaluator for the piano trainer.
// For each score step it checks the played note against the expected one and the
// onset/release timing against the expected duration, emits one registered verdict
// pulse together with avanca, and keeps a saturating error count.
//
// Handshake: there is no valid/ready pair. The control unit pulses inicia for one
// cycle; every verdict is a one-cycle pulse (exactly one of acerto/erro_nota/erro_tempo)
// coincident with a one-cycle avanca, both high only while the FSM is in REGISTRA.
// The score RAM is expected to present the next step on mem_* by the end of CARREGA.
module avaliador_ritmo #(
    parameter int NOTA_W  = 4,
    parameter int TEMPO_W = 4,
    parameter int SUBDIV  = 4,
    parameter int TOL     = 1,
    parameter int ERRO_W  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicia,
    input  logic               tick,
    input  logic [NOTA_W-1:0]  nota_in,
    input  logic [NOTA_W-1:0]  mem_nota,
    input  logic [TEMPO_W-1:0] mem_tempo,
    input  logic               fim_musica,
    output logic               avanca,
    output logic               acerto,
    output logic               erro_nota,
    output logic               erro_tempo,
    output logic [ERRO_W-1:0]  erros,
    output logic               ocupado,
    output logic               concluido,
    output logic [2:0]         db_estado
);

    // Counters must hold the longest hold limit D+TOL+1 for the largest mem_tempo.
    localparam int CNT_W = $clog2(((2**TEMPO_W) - 1) * SUBDIV + TOL + 2);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  TOL_C    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0]  TOL1_C   = CNT_W'(TOL + 1);
    localparam logic [CNT_W-1:0]  SUBDIV_C = CNT_W'(SUBDIV);
    localparam logic [ERRO_W-1:0] ERR_MAX  = '1;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ESPERA   = 3'd1,
        SEGURA   = 3'd2,
        REGISTRA = 3'd3,
        CARREGA  = 3'd4,
        FIM      = 3'd5
    } estado_t;

    estado_t            state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic [ERRO_W-1:0]  erros_q, erros_d;
    logic [NOTA_W-1:0]  nota_prev_q;
    logic               avanca_q, avanca_d;
    logic               acerto_q, acerto_d;
    logic               erro_nota_q, erro_nota_d;
    logic               erro_tempo_q, erro_tempo_d;
    logic               ocupado_q, ocupado_d;
    logic               concluido_q, concluido_d;

    logic [TEMPO_W-1:0] tempo_eff;
    logic [CNT_W-1:0]   d_val;
    logic [CNT_W-1:0]   hold_lim;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   h_inc;
    logic [CNT_W-1:0]   h_dist;
    logic               onset;
    logic               v_acerto, v_nota, v_tempo;

    // A zero duration is treated as one beat.
    assign tempo_eff = (mem_tempo == '0) ? TEMPO_W'(1) : mem_tempo;
    assign d_val     = CNT_W'(tempo_eff) * SUBDIV_C;
    assign hold_lim  = d_val + TOL1_C;
    // Onset is a 0 -> nonzero transition; a key held across steps never re-triggers.
    assign onset     = (nota_prev_q == '0) && (nota_in != '0);
    assign cnt_inc   = (tick && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    assign h_inc     = (tick && (h_q != CNT_MAX)) ? h_q + CNT_W'(1) : h_q;
    assign h_dist    = (h_q >= d_val) ? (h_q - d_val) : (d_val - h_q);

    // Next-state, verdict decision and registered-output next values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        h_d          = h_q;
        erros_d      = erros_q;
        avanca_d     = 1'b0;
        acerto_d     = 1'b0;
        erro_nota_d  = 1'b0;
        erro_tempo_d = 1'b0;
        v_acerto     = 1'b0;
        v_nota       = 1'b0;
        v_tempo      = 1'b0;

        case (state_q)
            OCIOSO: begin
                state_d = OCIOSO;
            end
            ESPERA: begin
                if (mem_nota != '0) begin
                    // Onset is judged against the pre-tick count.
                    if (onset) begin
                        if ((nota_in == mem_nota) && (cnt_q <= TOL_C)) begin
                            state_d = SEGURA;
                            h_d     = '0;
                        end else begin
                            v_nota = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= TOL1_C) v_tempo = 1'b1;
                    end
                end else begin
                    if (onset) begin
                        v_nota = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= d_val) v_acerto = 1'b1;
                    end
                end
            end
            SEGURA: begin
                // Release and note change are judged against the pre-tick hold count.
                if (nota_in == '0) begin
                    if (h_dist <= TOL_C) v_acerto = 1'b1;
                    else                 v_tempo  = 1'b1;
                end else if (nota_in != mem_nota) begin
                    v_nota = 1'b1;
                end else begin
                    h_d = h_inc;
                    if (h_inc >= hold_lim) v_tempo = 1'b1;
                end
            end
            REGISTRA: begin
                state_d = CARREGA;
            end
            CARREGA: begin
                cnt_d   = '0;
                state_d = fim_musica ? FIM : ESPERA;
            end
            FIM: begin
                state_d = FIM;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase

        if (v_acerto || v_nota || v_tempo) begin
            state_d      = REGISTRA;
            avanca_d     = 1'b1;
            acerto_d     = v_acerto;
            erro_nota_d  = v_nota;
            erro_tempo_d = v_tempo;
            if ((v_nota || v_tempo) && (erros_q != ERR_MAX)) erros_d = erros_q + ERRO_W'(1);
        end

        // inicia wins over everything: abort the step silently and restart.
        if (inicia) begin
            state_d      = ESPERA;
            cnt_d        = '0;
            h_d          = '0;
            erros_d      = '0;
            avanca_d     = 1'b0;
            acerto_d     = 1'b0;
            erro_nota_d  = 1'b0;
            erro_tempo_d = 1'b0;
        end

        ocupado_d   = (state_d != OCIOSO) && (state_d != FIM);
        concluido_d = (state_d == FIM);
    end

    // State, counters and all outputs registered with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= OCIOSO;
            cnt_q        <= '0;
            h_q          <= '0;
            erros_q      <= '0;
            nota_prev_q  <= '0;
            avanca_q     <= 1'b0;
            acerto_q     <= 1'b0;
            erro_nota_q  <= 1'b0;
            erro_tempo_q <= 1'b0;
            ocupado_q    <= 1'b0;
            concluido_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            h_q          <= h_d;
            erros_q      <= erros_d;
            nota_prev_q  <= nota_in;
            avanca_q     <= avanca_d;
            acerto_q     <= acerto_d;
            erro_nota_q  <= erro_nota_d;
            erro_tempo_q <= erro_tempo_d;
            ocupado_q    <= ocupado_d;
            concluido_q  <= concluido_d;
        end
    end

    assign avanca     = avanca_q;
    assign acerto     = acerto_q;
    assign erro_nota  = erro_nota_q;
    assign erro_tempo = erro_tempo_q;
    assign erros      = erros_q;
    assign ocupado    = ocupado_q;
    assign concluido  = concluido_q;
    assign db_estado  = state_q;

endmodule
